red_pitaya_pfd_divider_block: RTL and testbench
===============================================

# red_pitaya_pfd_divider_block

Next-generation edge-counting phase-frequency detector with parametrised widths, input synchronisers, per-channel programmable edge prescalers, selectable saturate/wrap integrator, and a lock detector. It compares two digital input signals, such as comparator outputs or trigger lines, and produces a signed error word proportional to accumulated phase difference. This feeds the PID/IQ signal chain in place of the fixed 14-bit edge PFD.

## Interface
- INTBITS, 20: internal integrator width (signed), ≥ OUTBITS
- OUTBITS, 14: output width; output = integrator[INTBITS-1 -: OUTBITS]
- DIVBITS, 8: prescaler control width
- SYNCSTAGES, 2: synchroniser flops per input, ≥ 2
- LOCKBITS, 16: lock-qualification counter width

- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- s1_i  in  1  signal 1, asynchronous to clk_i
- s2_i  in  1  signal 2, asynchronous to clk_i
- div1_i  in  DIVBITS  signal-1 prescaler: one pulse per div1_i+1 edges
- div2_i  in  DIVBITS  signal-2 prescaler, same rule
- falling_i  in  1  0: count rising edges; 1: count falling edges (both channels)
- wrap_i  in  1  0: saturate integrator; 1: two's-complement wrap
- clear_i  in  1  synchronous clear of integrator, prescalers, lock counter
- window_i  in  OUTBITS-1  lock window, unsigned magnitude
- integral_o  out  OUTBITS  signed error output
- sat_o  out  1  integrator at a limit (saturate mode only)
- lock_o  out  1  output inside window for 2^LOCKBITS-1 consecutive cycles

## Operation
- Asynchronous reset clears all state: integral_o=0, sat_o=0, lock_o=0, synchronisers, edge registers, prescaler counters.
- Each input passes through SYNCSTAGES flops, then a 1-flop history register. An edge is detected when synced/history equals 10 (rising) or 01 (falling), selected by falling_i.
- Prescaler n: counter cntn (DIVBITS) increments on each edge of channel n. When an edge occurs with cntn ≥ divn_i, cntn←0 and registered pulse pn=1 for one cycle. With divn_i=0, every edge pulses. A lowered divn_i below cntn takes effect on the next edge.
- Integrator update from {p1,p2}: 10 → +1; 01 → −1; 00 or 11 → hold.
- Saturate mode (wrap_i=0): increment at +max (0111…) holds; decrement at −max (1000…) holds. sat_o=1 whenever the register equals either limit, else 0.
- Wrap mode (wrap_i=1): plain modulo-2^INTBITS arithmetic; sat_o=0.
- Switching wrap_i takes effect on the next update; the value is not modified.
- clear_i=1: integrator, cnt1, cnt2, p1, p2, lock counter ←0 on that edge. clear_i has priority over pending pulses. Synchronisers and history are not cleared, so no spurious edge occurs.
- Lock detector: mag = |integral_o|, with −2^(OUTBITS-1) treated as 2^(OUTBITS-1), which is always outside the window.
  - If mag ≤ window_i, lockcnt increments and saturates at all-ones; otherwise lockcnt←0.
  - lock_o is registered: lock_o=1 iff lockcnt is all-ones.

## Timing
- Latency: with SYNCSTAGES=S, counting the clock edge that first samples the new input level as edge 1, pn asserts after edge S+1 and integral_o/sat_o update after edge S+2. For S=2, that is 4 edges.
- lock_o lags integral_o by one cycle plus qualification. The first lock_o=1 occurs 2^LOCKBITS cycles after integral_o enters the window and stays there.
- Each input level must be stable ≥ 2 clk_i cycles for guaranteed detection. Faster toggling may drop edges; this is not an error condition.
- Simultaneous p1/p2 on the same cycle cancel; no edge is lost from either prescaler count.
- Reset assertion mid-count clears immediately without waiting for a clock. Release is applied synchronously to clk_i by the top level.

## Test plan
- Reset, then s1 at clk/10 and s2 static, div=0, saturate, INTBITS=OUTBITS=14 → integral_o +1 per s1 rising edge, first step 4 edges after the sampled edge. Reaches 8191, sat_o=1, holds.
- Same with s2 only, wrap_i=1 → counts down from 0 to −8192, next edge gives +8191, sat_o stays 0.
- s1 and s2 identical clk/8 square waves → integral_o stays 0. Simultaneous-pulse cancellation is checked on every cycle.
- div1_i=3, div2_i=0, s1 at 4× the s2 frequency → net drift 0 ±1. Change div1_i to 1 mid-count with cnt1=3 → pulse on next edge, cnt1←0.
- falling_i=1: pulse s1 high for 3 cycles → one increment aligned to the falling edge, none at the rising edge.
- LOCKBITS=4, window_i=5, integral held at −3 → lock_o=1 after 16 cycles. One step to 6 → lock_o=0 next cycle. clear_i pulse → integral_o=0, lock_o=0, sat_o=0.

Source files
------------

// File: rtl/red_pitaya_pfd_divider_block.sv
// Edge-counting phase-frequency detector: synchronised inputs, per-channel edge
// prescalers, saturating/wrapping signed integrator and a window lock detector.
module red_pitaya_pfd_divider_block #(
  parameter int INTBITS    = 20,
  parameter int OUTBITS    = 14,
  parameter int DIVBITS    = 8,
  parameter int SYNCSTAGES = 2,
  parameter int LOCKBITS   = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      s1_i,
  input  logic                      s2_i,
  input  logic [DIVBITS-1:0]        div1_i,
  input  logic [DIVBITS-1:0]        div2_i,
  input  logic                      falling_i,
  input  logic                      wrap_i,
  input  logic                      clear_i,
  input  logic [OUTBITS-2:0]        window_i,
  output logic signed [OUTBITS-1:0] integral_o,
  output logic                      sat_o,
  output logic                      lock_o
);

  localparam logic [DIVBITS-1:0]        DIV_ONE   = DIVBITS'(1);
  localparam logic signed [INTBITS-1:0] INT_ONE   = INTBITS'(1);
  localparam logic signed [INTBITS-1:0] INT_MAX   = {1'b0, {(INTBITS-1){1'b1}}};
  localparam logic signed [INTBITS-1:0] INT_MIN   = {1'b1, {(INTBITS-1){1'b0}}};
  localparam logic [OUTBITS-1:0]        OUT_ONE   = OUTBITS'(1);
  localparam logic [LOCKBITS-1:0]       LOCK_ONE  = LOCKBITS'(1);
  localparam logic [LOCKBITS-1:0]       LOCK_FULL = '1;

  logic [SYNCSTAGES-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic                         hist1_q, hist1_d, hist2_q, hist2_d;
  logic [DIVBITS-1:0]           cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic                         p1_q, p1_d, p2_q, p2_d;
  logic signed [INTBITS-1:0]    integ_q, integ_d;
  logic                         sat_q, sat_d;
  logic [LOCKBITS-1:0]          lockcnt_q, lockcnt_d;
  logic                         lock_q, lock_d;

  logic                         s1_sync, s2_sync;
  logic                         edge1_det, edge2_det;
  logic [OUTBITS-1:0]           out_u, mag;
  logic                         in_win;

  assign s1_sync    = sync1_q[SYNCSTAGES-1];
  assign s2_sync    = sync2_q[SYNCSTAGES-1];
  assign integral_o = integ_q[INTBITS-1 -: OUTBITS];
  assign sat_o      = sat_q;
  assign lock_o     = lock_q;

  // Synchronisers and history are deliberately left out of clear_i so that
  // clearing never manufactures an edge.
  always_comb begin
    sync1_d   = {sync1_q[SYNCSTAGES-2:0], s1_i};
    sync2_d   = {sync2_q[SYNCSTAGES-2:0], s2_i};
    hist1_d   = s1_sync;
    hist2_d   = s2_sync;
    edge1_det = falling_i ? (~s1_sync & hist1_q) : (s1_sync & ~hist1_q);
    edge2_det = falling_i ? (~s2_sync & hist2_q) : (s2_sync & ~hist2_q);
  end

  always_comb begin
    cnt1_d = cnt1_q;
    p1_d   = 1'b0;
    cnt2_d = cnt2_q;
    p2_d   = 1'b0;
    if (clear_i) begin
      cnt1_d = '0;
      cnt2_d = '0;
    end else begin
      if (edge1_det) begin
        if (cnt1_q >= div1_i) begin
          cnt1_d = '0;
          p1_d   = 1'b1;
        end else begin
          cnt1_d = cnt1_q + DIV_ONE;
        end
      end
      if (edge2_det) begin
        if (cnt2_q >= div2_i) begin
          cnt2_d = '0;
          p2_d   = 1'b1;
        end else begin
          cnt2_d = cnt2_q + DIV_ONE;
        end
      end
    end
  end

  always_comb begin
    integ_d = integ_q;
    case ({p1_q, p2_q})
      2'b10:   if (wrap_i || (integ_q != INT_MAX)) integ_d = integ_q + INT_ONE;
      2'b01:   if (wrap_i || (integ_q != INT_MIN)) integ_d = integ_q - INT_ONE;
      default: integ_d = integ_q;
    endcase
    if (clear_i) integ_d = '0;
    sat_d = ~clear_i & ~wrap_i & ((integ_d == INT_MAX) | (integ_d == INT_MIN));
  end

  // The most negative output maps to 2^(OUTBITS-1), which no window can reach.
  always_comb begin
    out_u     = integral_o;
    mag       = out_u[OUTBITS-1] ? (~out_u + OUT_ONE) : out_u;
    in_win    = (mag <= {1'b0, window_i});
    lockcnt_d = '0;
    if (!clear_i && in_win) begin
      lockcnt_d = (lockcnt_q == LOCK_FULL) ? lockcnt_q : (lockcnt_q + LOCK_ONE);
    end
    lock_d = ~clear_i & in_win & (lockcnt_q == LOCK_FULL);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist1_q   <= 1'b0;
      hist2_q   <= 1'b0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      integ_q   <= '0;
      sat_q     <= 1'b0;
      lockcnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist1_q   <= hist1_d;
      hist2_q   <= hist2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      integ_q   <= integ_d;
      sat_q     <= sat_d;
      lockcnt_q <= lockcnt_d;
      lock_q    <= lock_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_pfd_divider_block.sv
// Self-checking bench for red_pitaya_pfd_divider_block: an arithmetic reference
// model compared every cycle, plus directed literal checks of key behaviours.
module tb_red_pitaya_pfd_divider_block;

  localparam int INTB  = 14;
  localparam int OUTB  = 14;
  localparam int DIVB  = 8;
  localparam int LOCKB = 4;
  localparam int MAXV  = (1 << (INTB - 1)) - 1;
  localparam int MINV  = -(1 << (INTB - 1));
  localparam int SPAN  = 1 << INTB;
  localparam int QUAL  = (1 << LOCKB) - 1;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic                   s1_i, s2_i;
  logic [DIVB-1:0]        div1_i, div2_i;
  logic                   falling_i, wrap_i, clear_i;
  logic [OUTB-2:0]        window_i;
  logic signed [OUTB-1:0] integral_o;
  logic                   sat_o, lock_o;

  int n_checks = 0;
  int n_fail   = 0;

  red_pitaya_pfd_divider_block #(
    .INTBITS(INTB), .OUTBITS(OUTB), .DIVBITS(DIVB), .SYNCSTAGES(2), .LOCKBITS(LOCKB)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .s1_i(s1_i), .s2_i(s2_i),
    .div1_i(div1_i), .div2_i(div2_i), .falling_i(falling_i), .wrap_i(wrap_i),
    .clear_i(clear_i), .window_i(window_i), .integral_o(integral_o),
    .sat_o(sat_o), .lock_o(lock_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an input transition first sampled at edge i becomes a
  // prescaler event at edge i+2 and an integrator step at edge i+3.
  int m_int, m_cnt1, m_cnt2, m_run;
  bit m_p1, m_p2, m_sat, m_lock;
  bit [2:0] h1, h2;

  task automatic model_step();
    bit e1, e2, inwin;
    int nxt, mag;
    if (!rstn_i) begin
      m_int = 0; m_cnt1 = 0; m_cnt2 = 0; m_run = 0;
      m_p1 = 0; m_p2 = 0; m_sat = 0; m_lock = 0;
      h1 = '0; h2 = '0;
      return;
    end
    e1 = falling_i ? (!h1[1] && h1[2]) : (h1[1] && !h1[2]);
    e2 = falling_i ? (!h2[1] && h2[2]) : (h2[1] && !h2[2]);
    if (clear_i) begin
      m_int = 0; m_cnt1 = 0; m_cnt2 = 0; m_run = 0;
      m_p1 = 0; m_p2 = 0; m_sat = 0; m_lock = 0;
    end else begin
      mag   = (m_int < 0) ? -m_int : m_int;
      inwin = (mag <= int'(window_i));
      if (inwin) begin
        m_lock = (m_run >= QUAL);
        m_run++;
      end else begin
        m_lock = 0;
        m_run  = 0;
      end
      nxt = m_int + int'(m_p1) - int'(m_p2);
      if (wrap_i) begin
        if (nxt > MAXV) nxt -= SPAN;
        if (nxt < MINV) nxt += SPAN;
      end else begin
        if (nxt > MAXV) nxt = MAXV;
        if (nxt < MINV) nxt = MINV;
      end
      m_int = nxt;
      m_sat = !wrap_i && (m_int == MAXV || m_int == MINV);
      m_p1 = 0;
      m_p2 = 0;
      if (e1) begin
        if (m_cnt1 >= int'(div1_i)) begin m_cnt1 = 0; m_p1 = 1; end
        else m_cnt1++;
      end
      if (e2) begin
        if (m_cnt2 >= int'(div2_i)) begin m_cnt2 = 0; m_p2 = 1; end
        else m_cnt2++;
      end
    end
    h1 = {h1[1:0], s1_i};
    h2 = {h2[1:0], s2_i};
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      model_step();
      #1;
      chk("model_integral", int'(integral_o), m_int);
      chk("model_sat", int'(sat_o), int'(m_sat));
      chk("model_lock", int'(lock_o), int'(m_lock));
    end
  end

  task automatic s1_pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      s1_i = 1'b1; repeat (hi) @(negedge clk_i);
      s1_i = 1'b0; repeat (lo) @(negedge clk_i);
    end
  endtask

  task automatic s2_pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      s2_i = 1'b1; repeat (hi) @(negedge clk_i);
      s2_i = 1'b0; repeat (lo) @(negedge clk_i);
    end
  endtask

  task automatic both_pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      s1_i = 1'b1; s2_i = 1'b1; repeat (hi) @(negedge clk_i);
      s1_i = 1'b0; s2_i = 1'b0; repeat (lo) @(negedge clk_i);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk_i); clear_i = 1'b1;
    @(negedge clk_i); clear_i = 1'b0;
  endtask

  task automatic wait_int(input int target, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk_i); #1; k++;
    end while (int'(integral_o) != target && k < budget);
    if (int'(integral_o) != target) chk("wait_timeout", int'(integral_o), target);
  endtask

  initial begin
    rstn_i = 1'b0; s1_i = 1'b0; s2_i = 1'b0; div1_i = '0; div2_i = '0;
    falling_i = 1'b0; wrap_i = 1'b0; clear_i = 1'b0; window_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_integral", int'(integral_o), 0);
    chk("reset_sat", int'(sat_o), 0);
    chk("reset_lock", int'(lock_o), 0);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // first step lands on the fourth edge after the level is first sampled
    s1_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i); #1;
      if (k < 4) chk("latency_hold", int'(integral_o), 0);
      else       chk("latency_step", int'(integral_o), 1);
    end
    @(negedge clk_i); s1_i = 1'b0;
    repeat (2) @(negedge clk_i);

    s1_pulses(8195, 2, 2);
    repeat (6) @(negedge clk_i);
    chk("up_sat_value", int'(integral_o), 8191);
    chk("up_sat_flag", int'(sat_o), 1);

    wrap_i = 1'b1;
    s1_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("wrap_to_min", int'(integral_o), -8192);
    chk("wrap_no_sat", int'(sat_o), 0);
    wrap_i = 1'b0;
    s2_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("sat_hold_min", int'(integral_o), -8192);
    chk("sat_flag_min", int'(sat_o), 1);
    wrap_i = 1'b1;
    s2_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("wrap_to_max", int'(integral_o), 8191);
    chk("wrap_max_no_sat", int'(sat_o), 0);

    pulse_clear();
    chk("clear_zero", int'(integral_o), 0);
    s2_pulses(5, 2, 2); repeat (4) @(negedge clk_i);
    chk("wrap_down", int'(integral_o), -5);
    wrap_i = 1'b0;

    pulse_clear();
    both_pulses(10, 4, 4); repeat (6) @(negedge clk_i);
    chk("same_freq", int'(integral_o), 0);

    pulse_clear();
    div1_i = 8'd3;
    fork
      s1_pulses(40, 2, 2);
      s2_pulses(10, 8, 8);
    join
    repeat (6) @(negedge clk_i);
    chk("prescale_net", int'(integral_o), 0);

    pulse_clear();
    s1_pulses(3, 2, 2); repeat (4) @(negedge clk_i);
    chk("div_no_pulse", int'(integral_o), 0);
    div1_i = 8'd1;
    s1_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("div_lowered", int'(integral_o), 1);
    s1_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("div_restart", int'(integral_o), 1);
    s1_pulses(1, 2, 2); repeat (4) @(negedge clk_i);
    chk("div_second", int'(integral_o), 2);
    div1_i = 8'd0;

    pulse_clear();
    falling_i = 1'b1;
    @(negedge clk_i); s1_i = 1'b1;
    repeat (3) @(negedge clk_i); s1_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i); #1;
      if (k < 4) chk("falling_hold", int'(integral_o), 0);
      else       chk("falling_step", int'(integral_o), 1);
    end
    @(negedge clk_i); falling_i = 1'b0;

    pulse_clear();
    window_i = 13'd5;
    s2_pulses(6, 2, 2); repeat (4) @(negedge clk_i);
    chk("lock_outside", int'(lock_o), 0);
    s1_i = 1'b1;
    wait_int(-5, 20);
    repeat (15) @(posedge clk_i);
    #1 chk("lock_early", int'(lock_o), 0);
    @(posedge clk_i);
    #1 chk("lock_on", int'(lock_o), 1);
    @(negedge clk_i); s1_i = 1'b0;
    repeat (2) @(negedge clk_i);
    s1_pulses(2, 2, 2); repeat (4) @(negedge clk_i);
    chk("lock_hold_m3", int'(lock_o), 1);
    s1_pulses(8, 2, 2); repeat (4) @(negedge clk_i);
    chk("lock_at_5", int'(lock_o), 1);
    s1_i = 1'b1;
    wait_int(6, 20);
    chk("lock_exit_edge", int'(lock_o), 1);
    @(posedge clk_i);
    #1 chk("lock_drop", int'(lock_o), 0);
    @(negedge clk_i); s1_i = 1'b0;
    pulse_clear();
    chk("clr_integral", int'(integral_o), 0);
    chk("clr_lock", int'(lock_o), 0);
    chk("clr_sat", int'(sat_o), 0);

    s1_pulses(2, 2, 2); repeat (4) @(negedge clk_i);
    chk("pre_reset", int'(integral_o), 2);
    @(posedge clk_i);
    #3 rstn_i = 1'b0;
    #1;
    chk("async_rst_integral", int'(integral_o), 0);
    chk("async_rst_sat", int'(sat_o), 0);
    chk("async_rst_lock", int'(lock_o), 0);
    @(negedge clk_i); @(negedge clk_i); rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
